// File: rtl/cdr_lock_sequencer_pkg.sv
// Shared types and default timing for the CDR bring-up sequencer.
// The state encoding is read back over JTAG, so the numeric values must stay fixed.
package cdr_seq_pack;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      INBUF   = 4'd1,
      V2T     = 4'd2,
      RELEASE = 4'd3,
      EXT_PI  = 4'd4,
      ACQ     = 4'd5,
      RECORD  = 4'd6,
      DONE    = 4'd7,
      FAIL    = 4'd8
   } cdr_seq_state_t;

   localparam int DEF_PD_WIDTH    = 10;
   localparam int DEF_T_STEP      = 64;
   localparam int DEF_T_EXT_PI    = 1024;
   localparam int DEF_LOCK_THRESH = 4;
   localparam int DEF_LOCK_COUNT  = 256;
   localparam int DEF_TIMEOUT     = 65536;
   localparam int DEF_RECORD_LEN  = 512;

   typedef struct packed {
      logic en_inbuf;
      logic en_v2t;
      logic int_rstb;
      logic en_ext_pi_ctl_cdr;
      logic locked;
      logic record_en;
      logic done;
      logic fail;
   } cdr_seq_out_t;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Enables accumulate through bring-up and stay on in DONE/FAIL; FAIL hands the PI back to the external code.
   function automatic cdr_seq_out_t seq_decode(input cdr_seq_state_t s);
      cdr_seq_out_t o;
      o = '0;
      o.en_ext_pi_ctl_cdr = 1'b1;
      case (s)
         INBUF: begin
            o.en_inbuf = 1'b1;
         end
         V2T: begin
            o.en_inbuf = 1'b1;
            o.en_v2t   = 1'b1;
         end
         RELEASE, EXT_PI: begin
            o.en_inbuf = 1'b1;
            o.en_v2t   = 1'b1;
            o.int_rstb = 1'b1;
         end
         ACQ: begin
            o.en_inbuf          = 1'b1;
            o.en_v2t            = 1'b1;
            o.int_rstb          = 1'b1;
            o.en_ext_pi_ctl_cdr = 1'b0;
         end
         RECORD: begin
            o.en_inbuf          = 1'b1;
            o.en_v2t            = 1'b1;
            o.int_rstb          = 1'b1;
            o.en_ext_pi_ctl_cdr = 1'b0;
            o.locked            = 1'b1;
            o.record_en         = 1'b1;
         end
         DONE: begin
            o.en_inbuf          = 1'b1;
            o.en_v2t            = 1'b1;
            o.int_rstb          = 1'b1;
            o.en_ext_pi_ctl_cdr = 1'b0;
            o.locked            = 1'b1;
            o.done              = 1'b1;
         end
         FAIL: begin
            o.en_inbuf = 1'b1;
            o.en_v2t   = 1'b1;
            o.int_rstb = 1'b1;
            o.fail     = 1'b1;
         end
         default: begin
            o.en_inbuf = 1'b0;
         end
      endcase
      return o;
   endfunction

endpackage

// File: rtl/cdr_lock_sequencer_if.sv
// Control/status bundle between the JTAG test-control side (master) and the sequencer (slave).
// relock_cnt exists only when CDR_RELOCK_EN is defined.
interface cdr_lock_sequencer_if #(
   parameter int PD_WIDTH = 10
);

   logic                       start;
   logic                       abort;
   logic                       pd_valid;
   logic signed [PD_WIDTH-1:0] pd_err;
   logic                       en_inbuf;
   logic                       en_v2t;
   logic                       int_rstb;
   logic                       en_ext_pi_ctl_cdr;
   logic                       locked;
   logic                       record_en;
   logic                       done;
   logic                       fail;
   logic [3:0]                 state;
`ifdef CDR_RELOCK_EN
   logic [7:0]                 relock_cnt;
`endif

   modport master (
      output start, abort, pd_valid, pd_err,
      input  en_inbuf, en_v2t, int_rstb, en_ext_pi_ctl_cdr, locked, record_en, done, fail,
`ifdef CDR_RELOCK_EN
      input  relock_cnt,
`endif
      input  state
   );

   modport slave (
      input  start, abort, pd_valid, pd_err,
      output en_inbuf, en_v2t, int_rstb, en_ext_pi_ctl_cdr, locked, record_en, done, fail,
`ifdef CDR_RELOCK_EN
      output relock_cnt,
`endif
      output state
   );

endinterface

// File: rtl/cdr_lock_sequencer_lock_detector.sv
// Lock detector: counts consecutive in-window phase-detector samples.
// lock reflects the count about to be stored, so the sequencer can act on the sample that completes the run.
module cdr_lock_detector #(
   parameter int PD_WIDTH    = 10,
   parameter int LOCK_THRESH = 4,
   parameter int LOCK_COUNT  = 256
) (
   input  logic                       clk,
   input  logic                       rstb,
   input  logic                       clr,
   input  logic                       pd_valid,
   input  logic signed [PD_WIDTH-1:0] pd_err,
   output logic                       lock
);

   localparam int MW  = PD_WIDTH + 1;
   localparam int LCW = $clog2(LOCK_COUNT) + 1;
   localparam logic [LCW-1:0] LOCK_FULL = LCW'(LOCK_COUNT);
   localparam logic [LCW-1:0] LCNT_ONE  = LCW'(1);
   localparam logic [MW-1:0]  THRESH    = MW'(LOCK_THRESH);

   logic signed [MW-1:0] err_ext;
   logic [MW-1:0]        err_mag;
   logic                 in_window;
   logic [LCW-1:0]       cnt_q;
   logic [LCW-1:0]       cnt_d;

   // One extra bit keeps |most negative code| representable.
   assign err_ext   = {pd_err[PD_WIDTH-1], pd_err};
   assign err_mag   = err_ext[MW-1] ? -err_ext : err_ext;
   assign in_window = (err_mag <= THRESH);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (pd_valid) begin
         if (!in_window) begin
            cnt_d = '0;
         end else if (cnt_q != LOCK_FULL) begin
            cnt_d = cnt_q + LCNT_ONE;
         end
      end
   end

   assign lock = (cnt_d == LOCK_FULL);

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cdr_lock_sequencer.sv
// Deterministic RX front-end / MM CDR bring-up sequencer with lock detection and record window.
// Define CDR_RELOCK_EN to drop back to acquisition on a large phase error during RECORD.
module cdr_lock_sequencer
   import cdr_seq_pack::*;
#(
   parameter int PD_WIDTH    = DEF_PD_WIDTH,
   parameter int T_STEP      = DEF_T_STEP,
   parameter int T_EXT_PI    = DEF_T_EXT_PI,
   parameter int LOCK_THRESH = DEF_LOCK_THRESH,
   parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int RECORD_LEN  = DEF_RECORD_LEN
) (
   input logic                 clk,
   input logic                 rstb,
   cdr_lock_sequencer_if.slave bus
);

   localparam int CW = $clog2(max_of(max_of(T_STEP, T_EXT_PI), max_of(RECORD_LEN, TIMEOUT))) + 1;
   localparam logic [CW-1:0] LOAD_STEP    = CW'(T_STEP - 1);
   localparam logic [CW-1:0] LOAD_EXT     = CW'(T_EXT_PI - 1);
   localparam logic [CW-1:0] LOAD_TIMEOUT = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] LOAD_RECORD  = CW'(RECORD_LEN - 1);
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);

   cdr_seq_state_t state_q;
   cdr_seq_state_t state_d;
   logic [CW-1:0]  cnt_q;
   logic [CW-1:0]  cnt_d;
   cdr_seq_out_t   out_q;
   logic           start_q;
   logic           start_edge;
   logic           lock;
   logic           lock_clr;
   logic           relock_hit;

   assign start_edge = bus.start & ~start_q;
   // Holding the detector clear outside ACQ guarantees a fresh count on every entry.
   assign lock_clr   = (state_q != ACQ);

   cdr_lock_detector #(
      .PD_WIDTH   (PD_WIDTH),
      .LOCK_THRESH(LOCK_THRESH),
      .LOCK_COUNT (LOCK_COUNT)
   ) u_lock_det (
      .clk     (clk),
      .rstb    (rstb),
      .clr     (lock_clr),
      .pd_valid(bus.pd_valid),
      .pd_err  (bus.pd_err),
      .lock    (lock)
   );

`ifdef CDR_RELOCK_EN
   localparam int MW = PD_WIDTH + 1;
   localparam logic [MW-1:0] RELOCK_LIMIT = MW'(4 * LOCK_THRESH);

   logic signed [MW-1:0] err_ext;
   logic [MW-1:0]        err_mag;
   logic [7:0]           relock_q;

   assign err_ext    = {bus.pd_err[PD_WIDTH-1], bus.pd_err};
   assign err_mag    = err_ext[MW-1] ? -err_ext : err_ext;
   assign relock_hit = (state_q == RECORD) && bus.pd_valid && (err_mag > RELOCK_LIMIT);

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         relock_q <= '0;
      end else if (bus.abort) begin
         relock_q <= '0;
      end else if (relock_hit && (state_d == ACQ) && (relock_q != 8'hFF)) begin
         relock_q <= relock_q + 8'd1;
      end
   end

   assign bus.relock_cnt = relock_q;
`else
   assign relock_hit = 1'b0;
`endif

   // Next state plus shared down-counter; abort overrides everything, lock beats timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_edge) state_d = INBUF;
         INBUF:   if (cnt_q == '0) state_d = V2T;
         V2T:     if (cnt_q == '0) state_d = RELEASE;
         RELEASE: if (cnt_q == '0) state_d = EXT_PI;
         EXT_PI:  if (cnt_q == '0) state_d = ACQ;
         ACQ: begin
            if (lock) begin
               state_d = RECORD;
            end else if (cnt_q == '0) begin
               state_d = FAIL;
            end
         end
         RECORD: begin
            if (relock_hit) begin
               state_d = ACQ;
            end else if (cnt_q == '0) begin
               state_d = DONE;
            end
         end
         DONE, FAIL: state_d = state_q;
         default:    state_d = IDLE;
      endcase
      if (bus.abort) begin
         state_d = IDLE;
      end

      cnt_d = (cnt_q != '0) ? (cnt_q - CNT_ONE) : cnt_q;
      if (state_d != state_q) begin
         case (state_d)
            INBUF, V2T, RELEASE: cnt_d = LOAD_STEP;
            EXT_PI:              cnt_d = LOAD_EXT;
            ACQ:                 cnt_d = LOAD_TIMEOUT;
            RECORD:              cnt_d = LOAD_RECORD;
            default:             cnt_d = '0;
         endcase
      end
   end

   // Outputs are decoded from the next state so they register together with it.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         start_q <= 1'b0;
         out_q   <= seq_decode(IDLE);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         start_q <= bus.start;
         out_q   <= seq_decode(state_d);
      end
   end

   assign bus.en_inbuf          = out_q.en_inbuf;
   assign bus.en_v2t            = out_q.en_v2t;
   assign bus.int_rstb          = out_q.int_rstb;
   assign bus.en_ext_pi_ctl_cdr = out_q.en_ext_pi_ctl_cdr;
   assign bus.locked            = out_q.locked;
   assign bus.record_en         = out_q.record_en;
   assign bus.done              = out_q.done;
   assign bus.fail              = out_q.fail;
   assign bus.state             = state_q;

endmodule

// File: tb/tb_cdr_lock_sequencer.sv
// Directed bench for cdr_lock_sequencer; timeout shortened to 4096 to keep the run short.
// Cycle index k counts rising edges after the start edge, k=0 being the edge that samples it.
module tb_cdr_lock_sequencer;
   import cdr_seq_pack::*;

   localparam int PDW      = 10;
   localparam int TO       = 4096;
   localparam int CLK_HALF = 5;

   logic clk = 1'b0;
   logic rstb;
   int   edge_cnt  = 0;
   int   base      = 0;
   int   pass_cnt  = 0;
   int   check_cnt = 0;
   logic rec_seen  = 1'b0;

   cdr_lock_sequencer_if #(.PD_WIDTH(PDW)) bus ();

   cdr_lock_sequencer #(
      .PD_WIDTH   (PDW),
      .T_STEP     (64),
      .T_EXT_PI   (1024),
      .LOCK_THRESH(4),
      .LOCK_COUNT (256),
      .TIMEOUT    (TO),
      .RECORD_LEN (512)
   ) dut (
      .clk (clk),
      .rstb(rstb),
      .bus (bus)
   );

   always #CLK_HALF clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   initial begin
      #(CLK_HALF * 2 * 40000);
      $display("[TB] FAIL watchdog: bench did not finish, passed %0d of %0d", pass_cnt, check_cnt);
      $fatal(1, "[TB] watchdog expired");
   end

   // Bit order: en_inbuf en_v2t int_rstb en_ext_pi_ctl_cdr locked record_en done fail
   function automatic logic [7:0] outs();
      return {bus.en_inbuf, bus.en_v2t, bus.int_rstb, bus.en_ext_pi_ctl_cdr,
              bus.locked, bus.record_en, bus.done, bus.fail};
   endfunction

   task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      check_cnt = check_cnt + 1;
      assert (obs === exp) pass_cnt = pass_cnt + 1;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (k=%0d)", tag, obs, exp, edge_cnt - base);
   endtask

   task automatic check_state(input string tag, input cdr_seq_state_t st, input logic [7:0] ov);
      check_output({tag, ".state"}, 16'(bus.state), 16'(st));
      check_output({tag, ".outs"}, 16'(outs()), 16'(ov));
   endtask

   // Runs negedge by negedge until the edge target_k has passed, driving pd inputs per mode.
   // Inputs driven after edge k are consumed at edge k+1, i.e. ACQ sample j = k - 1215.
   task automatic apply_stimulus(input int target_k, input int mode);
      int k;
      int j;
      int val;
      do begin
         @(negedge clk);
         k = edge_cnt - base;
         j = k - 1215;
         if (bus.record_en) rec_seen = 1'b1;
         bus.pd_valid = 1'b1;
         case (mode)
            1: val = ((j % 2) == 0) ? 4 : -4;
            2: begin
               if (j <= 255)      val = 3;
               else if (j == 256) val = 5;
               else if (j <= 511) val = -3;
               else if (j == 512) val = -512;
               else               val = 0;
            end
            3: begin
               bus.pd_valid = ((j & 3) == 0);
               val = bus.pd_valid ? 2 : 100;
            end
            4: val = 100;
            5: val = (k == 1549) ? 16 : ((k == 1599) ? 17 : 0);
            default: val = 0;
         endcase
         bus.pd_err = PDW'(val);
      end while (k < target_k);
   endtask

   task automatic begin_seq();
      @(negedge clk);
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      bus.pd_valid = 1'b1;
      bus.pd_err   = '0;
      @(negedge clk);
      bus.start = 1'b1;
      base      = edge_cnt + 1;
      rec_seen  = 1'b0;
   endtask

   task automatic do_abort(input string tag);
      @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check_state(tag, IDLE, 8'h10);
`ifdef CDR_RELOCK_EN
      check_output({tag, ".relock_cnt"}, 16'(bus.relock_cnt), 16'd0);
`endif
   endtask

   initial begin
      rstb         = 1'b0;
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      bus.pd_valid = 1'b0;
      bus.pd_err   = '0;
      repeat (3) @(negedge clk);
      check_state("reset", IDLE, 8'h10);
`ifdef CDR_RELOCK_EN
      check_output("reset.relock_cnt", 16'(bus.relock_cnt), 16'd0);
`endif
      rstb = 1'b1;
      repeat (2) @(negedge clk);
      check_state("idle", IDLE, 8'h10);

      $display("[TB] nominal bring-up, pd_err=0");
      begin_seq();
      apply_stimulus(0, 0);    check_state("A.inbuf", INBUF, 8'h90);
      apply_stimulus(63, 0);   check_state("A.inbuf_end", INBUF, 8'h90);
      apply_stimulus(64, 0);   check_state("A.v2t", V2T, 8'hD0);
      apply_stimulus(127, 0);  check_state("A.v2t_end", V2T, 8'hD0);
      apply_stimulus(128, 0);  check_state("A.release", RELEASE, 8'hF0);
      apply_stimulus(192, 0);  check_state("A.ext_pi", EXT_PI, 8'hF0);
      apply_stimulus(1215, 0); check_state("A.ext_pi_end", EXT_PI, 8'hF0);
      apply_stimulus(1216, 0); check_state("A.acq", ACQ, 8'hE0);
      apply_stimulus(1471, 0); check_state("A.acq_end", ACQ, 8'hE0);
      apply_stimulus(1472, 0); check_state("A.record", RECORD, 8'hEC);
      apply_stimulus(1983, 0); check_state("A.record_end", RECORD, 8'hEC);
      apply_stimulus(1984, 0); check_state("A.done", DONE, 8'hEA);
      apply_stimulus(1990, 0); check_state("A.done_sticky", DONE, 8'hEA);
      do_abort("A.abort_done");
      repeat (5) @(negedge clk);
      check_state("A.start_held", IDLE, 8'h10);

      $display("[TB] alternating +4/-4, abort mid-RECORD");
      begin_seq();
      apply_stimulus(1471, 1); check_state("B.acq_end", ACQ, 8'hE0);
      apply_stimulus(1472, 1); check_state("B.record", RECORD, 8'hEC);
      apply_stimulus(1600, 1); check_state("B.record_mid", RECORD, 8'hEC);
      do_abort("B.abort_record");

      $display("[TB] abort together with start edge");
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check_state("C.abort_start", IDLE, 8'h10);
      repeat (3) @(negedge clk);
      check_state("C.no_restart", IDLE, 8'h10);

      $display("[TB] lock window boundary, +5 and -512 clear the run");
      begin_seq();
      apply_stimulus(1472, 2); check_state("D.after_plus5", ACQ, 8'hE0);
      apply_stimulus(1728, 2); check_state("D.after_neg512", ACQ, 8'hE0);
      apply_stimulus(1983, 2); check_state("D.acq_end", ACQ, 8'hE0);
      apply_stimulus(1984, 2); check_state("D.record", RECORD, 8'hEC);
      do_abort("D.abort");

      $display("[TB] pd_valid every 4th cycle");
      begin_seq();
      apply_stimulus(1472, 3); check_state("E.no_early_lock", ACQ, 8'hE0);
      apply_stimulus(2239, 3); check_state("E.acq_end", ACQ, 8'hE0);
      apply_stimulus(2240, 3); check_state("E.record", RECORD, 8'hEC);
      do_abort("E.abort");

      $display("[TB] acquisition timeout with pd_err=+100");
      begin_seq();
      apply_stimulus(5311, 4); check_state("F.acq_end", ACQ, 8'hE0);
      apply_stimulus(5312, 4); check_state("F.timeout", FAIL, 8'hF1);
      apply_stimulus(5320, 4); check_state("F.sticky", FAIL, 8'hF1);
      check_output("F.record_never", 16'(rec_seen), 16'd0);
      do_abort("F.abort");

      $display("[TB] large error during RECORD");
      begin_seq();
      apply_stimulus(1472, 5); check_state("G.record", RECORD, 8'hEC);
      apply_stimulus(1550, 5); check_state("G.err16_kept", RECORD, 8'hEC);
`ifdef CDR_RELOCK_EN
      apply_stimulus(1599, 5); check_state("G.pre_relock", RECORD, 8'hEC);
      apply_stimulus(1600, 5); check_state("G.relock_acq", ACQ, 8'hE0);
      check_output("G.relock_cnt", 16'(bus.relock_cnt), 16'd1);
      apply_stimulus(1855, 5); check_state("G.reacq_end", ACQ, 8'hE0);
      apply_stimulus(1856, 5); check_state("G.rerecord", RECORD, 8'hEC);
      apply_stimulus(2367, 5); check_state("G.rerecord_end", RECORD, 8'hEC);
      apply_stimulus(2368, 5); check_state("G.done", DONE, 8'hEA);
      check_output("G.relock_cnt_done", 16'(bus.relock_cnt), 16'd1);
`else
      apply_stimulus(1600, 5); check_state("G.err17_ignored", RECORD, 8'hEC);
      apply_stimulus(1983, 5); check_state("G.record_end", RECORD, 8'hEC);
      apply_stimulus(1984, 5); check_state("G.done", DONE, 8'hEA);
`endif
      do_abort("G.abort");

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/cdr_lock_sequencer.md
Name: cdr_lock_sequencer

Overview:
Digital controller that brings up the RX front-end and the MM CDR loop in a fixed order, then opens a data-capture window.
- Bring-up order: input buffer, V2T, internal reset release, external PI code, then hand-off to the CDR.
- Declares lock from the phase-detector error stream and gates the ADC/TX recorders via record_en.
- Sits beside the JTAG test-control registers. Replaces software-timed enable sequencing with a deterministic on-chip sequence.

Parameters:
PD_WIDTH, 10, width of signed phase-detector error input
T_STEP, 64, clk cycles between successive bring-up enables
T_EXT_PI, 1024, clk cycles held on external PI code before CDR hand-off
LOCK_THRESH, 4, lock window: |pd_err| <= LOCK_THRESH counts as in-lock
LOCK_COUNT, 256, consecutive in-lock pd_valid samples required to declare lock
TIMEOUT, 65536, max clk cycles in ACQ before FAIL
RECORD_LEN, 512, clk cycles record_en stays high

Ports:
clk  input  1  sequencer clock (ADC-domain clk_adc)
rstb  input  1  asynchronous active-low reset
start  input  1  level; rising edge in IDLE starts the sequence
abort  input  1  synchronous; forces IDLE from any state
pd_valid  input  1  pd_err qualifier
pd_err  input  PD_WIDTH  signed MM phase-detector error
en_inbuf  output  1  input buffer enable
en_v2t  output  1  V2T enable
int_rstb  output  1  internal datapath reset, active-low
en_ext_pi_ctl_cdr  output  1  1 = PI driven by external code, 0 = CDR drives PI
locked  output  1  lock status
record_en  output  1  recorder enable window
done  output  1  sticky, sequence completed
fail  output  1  sticky, acquisition timeout
state  output  4  current state encoding, for JTAG readback

Behaviour:
- Reset is asynchronous and active-low on rstb. All state updates on rising clk.
- Reset values: en_inbuf=0, en_v2t=0, int_rstb=0, en_ext_pi_ctl_cdr=1, locked=0, record_en=0, done=0, fail=0, state=IDLE.
- All outputs are registered and decoded from state. Outputs change the cycle after a transition.
- Start detection: rising edge of start, sampled only in IDLE. A start held high after DONE/FAIL does not restart; it must drop then rise again.
- States and transitions (one shared down-counter, reloaded on entry to each state):
  - IDLE: on start edge -> INBUF.
  - INBUF: en_inbuf=1; after T_STEP cycles -> V2T.
  - V2T: adds en_v2t=1; after T_STEP cycles -> RELEASE.
  - RELEASE: adds int_rstb=1; after T_STEP cycles -> EXT_PI.
  - EXT_PI: holds en_ext_pi_ctl_cdr=1; after T_EXT_PI cycles -> ACQ.
  - ACQ: en_ext_pi_ctl_cdr=0; lock detector active. Lock -> RECORD. TIMEOUT cycles without lock -> FAIL.
  - RECORD: locked=1, record_en=1; after RECORD_LEN cycles -> DONE.
  - DONE: record_en=0, done=1. Enables stay on, locked stays 1.
  - FAIL: fail=1, en_ext_pi_ctl_cdr=1, enables stay on.
- Leaving DONE/FAIL: only via abort or reset.
- Lock detector:
  - |pd_err| is computed at PD_WIDTH+1 bits, so the most negative value has no overflow.
  - On each pd_valid with |pd_err| <= LOCK_THRESH the in-lock counter increments; on a pd_valid outside the window it clears to 0.
  - Cycles without pd_valid leave the counter unchanged.
  - Lock when the counter reaches LOCK_COUNT. The counter saturates there.
  - The counter is cleared on every entry to ACQ.
- Simultaneous events:
  - abort beats every transition, including start.
  - Lock and timeout in the same cycle: lock wins.
- abort: next cycle state=IDLE and every output returns to its reset value.
- Counter widths: $clog2 of the largest of T_STEP, T_EXT_PI, RECORD_LEN, TIMEOUT, plus 1.

Optional Feature:
CDR_RELOCK_EN:
- Defined: in RECORD, any pd_valid with |pd_err| > 4*LOCK_THRESH drops locked and record_en next cycle, returns to ACQ with a fresh lock counter and fresh timeout, and increments an 8-bit saturating output relock_cnt (port present only when defined). relock_cnt is cleared by reset and by abort.
- Undefined: RECORD ignores pd_err entirely and no relock_cnt port exists.

Decomposition:
- Shared package cdr_seq_pack:
  - typedef enum logic [3:0] cdr_seq_state_t: IDLE=0, INBUF=1, V2T=2, RELEASE=3, EXT_PI=4, ACQ=5, RECORD=6, DONE=7, FAIL=8.
  - Default timing constants.
- One sub-module: cdr_lock_detector, with inputs clk, rstb, clr, pd_valid, pd_err and output lock. It contains the absolute-value window and the consecutive counter.

Test Plan:
- Reset and start, with pd_err=0 and pd_valid every cycle: en_inbuf rises 1 cycle after the start edge, en_v2t after +64, int_rstb after +128, en_ext_pi_ctl_cdr falls at +192+1024. locked and record_en rise 256 cycles after ACQ entry, record_en lasts 512 cycles, then done=1.
- Lock boundary: pd_err alternating +4/-4 -> lock. Pattern of 255 samples at +3 then one at +5 -> counter clears, no lock until 256 more in-window samples. pd_err=-512 -> treated as out-of-window, no overflow.
- pd_valid gaps: in-window samples every 4th cycle -> lock after 256 valid samples (about 1024 cycles), not 256 cycles.
- Timeout: pd_err=+100 constantly -> FAIL exactly 65536 cycles after ACQ entry, fail=1, en_ext_pi_ctl_cdr=1, record_en never asserted.
- Abort and restart:
  - abort mid-RECORD -> next cycle all outputs at reset values, state=IDLE.
  - start held high -> no restart until it falls and rises again.
  - abort asserted together with a start edge -> stays IDLE.
- CDR_RELOCK_EN: in RECORD inject pd_err=+17 (LOCK_THRESH=4) -> record_en drops, state=ACQ, relock_cnt=1. Re-lock completes the full 512-cycle RECORD window, then DONE.
